mem_word_access: RTL and testbench

- Bus initiator between the SRP16 core and the byte-wide program/data memory.
- Turns one 16-bit load/store request from the core into one or two byte cycles on the memory port: low byte at addr, high byte at addr+1.
- Assembles the 16-bit read result and returns it with a single-cycle response pulse.
- Sole driver of memory din/addrin/read/write.

---
 rtl/srp16_mem_pkg.sv | 25 ++
 rtl/mem_word_access.sv | 166 ++++++++++++++++
 tb/tb_mem_word_access.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/srp16_mem_pkg.sv
// Shared definitions for the SRP16 byte-wide memory initiator:
// FSM state encoding, default address width and byte-lane helpers.
package srp16_mem_pkg;

    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Byte-lane index within a 16-bit word
    localparam logic LANE_LO = 1'b0;  // bits [7:0]
    localparam logic LANE_HI = 1'b1;  // bits [15:8]

    function automatic logic [7:0] lane_byte(
        input logic [15:0] d,
        input logic        lane
    );
        return lane ? d[15:8] : d[7:0];
    endfunction

endpackage

// File: rtl/mem_word_access.sv
// mem_word_access: splits one 16-bit core load/store into one or two
// byte cycles on the program/data memory port and returns the result.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/ready/write/byte/addr/wdata   core request
//   rsp_valid/rdata/err     one-cycle completion pulse and load data
//   mem_din/addr/read/write memory drive (sole driver)
//   mem_dout                memory read data, [7:0] used
// Build option: MEM_ALIGN_CHECK_EN rejects odd word addresses with rsp_err.
module mem_word_access
    import srp16_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [15:0]       mem_dout
);

    state_t            r_state;
    state_t            w_next;
    logic              r_write;
    logic              r_byte;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [7:0]        r_first;
    logic [15:0]       r_rdata;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_lane;
    logic              w_first_lane;
    logic              w_second_lane;
    logic              w_unused_dout;

    assign w_unused_dout = ^mem_dout[15:8];

    // Second byte address wraps modulo 2^ADDR_W
    assign w_addr_nxt = r_addr + ADDR_W'(1);

    // Byte accesses always use lane [7:0]
    assign w_first_lane  = (r_byte || !BIG_ENDIAN) ? LANE_LO : LANE_HI;
    assign w_second_lane = BIG_ENDIAN ? LANE_LO : LANE_HI;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misalign;
    logic r_err;

    assign w_misalign = ~req_byte & req_addr[0];
    assign rsp_err    = r_err & (r_state == ST_RESP);
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_lane    = LANE_LO;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_din   = 8'h00;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = ST_LO;
`ifdef MEM_ALIGN_CHECK_EN
                    if (w_misalign) w_next = ST_RESP;
`endif
                end
            end
            ST_LO: begin
                w_lane    = w_first_lane;
                mem_read  = ~r_write;
                mem_write = r_write;
                mem_addr  = r_addr;
                w_next    = r_byte ? ST_RESP : ST_HI;
            end
            ST_HI: begin
                w_lane    = w_second_lane;
                mem_read  = ~r_write;
                mem_write = r_write;
                mem_addr  = w_addr_nxt;
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (mem_write) mem_din = lane_byte(r_wdata, w_lane);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 16'h0000;
            r_first <= 8'h00;
            r_rdata <= 16'h0000;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_byte  <= req_byte;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                    end
                end
                ST_LO: begin
                    // rsp_rdata only changes when a load completes
                    if (!r_write) begin
                        if (r_byte) r_rdata <= {8'h00, mem_dout[7:0]};
                        else        r_first <= mem_dout[7:0];
                    end
                end
                ST_HI: begin
                    if (!r_write) begin
                        r_rdata <= BIG_ENDIAN ? {r_first, mem_dout[7:0]}
                                              : {mem_dout[7:0], r_first};
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && req_valid) begin
            r_err <= w_misalign;
        end
    end
`endif

endmodule

// File: tb/tb_mem_word_access.sv
// Self-checking bench for mem_word_access: byte memory model, transaction
// reference model with per-cycle compare, plus directed literal checks.
module tb_mem_word_access;

    localparam int AW = 16;
    localparam bit BE = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic          req_byte = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [15:0]   req_wdata = 16'h0000;
    logic          rsp_valid;
    logic [15:0]   rsp_rdata;
    logic          rsp_err;
    logic [7:0]    mem_din;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [15:0]   mem_dout;

    always #5 clk = ~clk;

    mem_word_access #(.ADDR_W(AW), .BIG_ENDIAN(BE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_din(mem_din), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
    );

    // Memory device and reference image
    logic [7:0] mem   [0:65535];
    logic [7:0] ref_m [0:65535];

    assign mem_dout = mem_read ? {8'h00, mem[mem_addr]} : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] = mem_din;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: one outstanding transaction at most
    int          cyc = 0;
    int          acc_cnt = 0;
    bit          pend = 1'b0;
    int          pend_acc = 0;
    int          pend_n = 0;
    int          pend_nth = 0;
    bit          pend_write = 1'b0;
    bit          pend_upd = 1'b0;
    bit          pend_err = 1'b0;
    logic [15:0] pend_rdata = 16'h0000;
    logic [15:0] op_addr [2];
    logic [7:0]  op_byte [2];
    logic [15:0] model_rdata = 16'h0000;
    int          rsp_cyc = 0;
    int          reads_now = 0;
    int          last_reads = 0;
    logic        last_err = 1'b0;

    always @(posedge clk) begin : model
        logic [15:0] a0;
        logic [15:0] a1;
        bit          mis;
        cyc++;
        if (!rst_n) begin
            pend        = 1'b0;
            model_rdata = 16'h0000;
        end else begin
            // A store byte is committed at the edge closing its cycle
            if (pend && pend_write) begin
                for (int k = 0; k < pend_n; k++)
                    if (cyc == pend_acc + k + 1) ref_m[op_addr[k]] = op_byte[k];
            end
            if (req_valid && req_ready) begin
                a0         = req_addr;
                a1         = req_addr + 16'd1;
                mis        = ALIGN && !req_byte && req_addr[0];
                acc_cnt++;
                pend       = 1'b1;
                pend_acc   = cyc;
                pend_nth   = 0;
                reads_now  = 0;
                pend_write = req_write;
                pend_err   = mis;
                pend_n     = mis ? 0 : (req_byte ? 1 : 2);
                pend_upd   = !req_write && !mis;
                op_addr[0] = a0;
                op_addr[1] = a1;
                if (req_byte) begin
                    op_byte[0] = req_wdata[7:0];
                    op_byte[1] = 8'h00;
                    pend_rdata = {8'h00, ref_m[a0]};
                end else if (BE) begin
                    op_byte[0] = req_wdata[15:8];
                    op_byte[1] = req_wdata[7:0];
                    pend_rdata = {ref_m[a0], ref_m[a1]};
                end else begin
                    op_byte[0] = req_wdata[7:0];
                    op_byte[1] = req_wdata[15:8];
                    pend_rdata = {ref_m[a1], ref_m[a0]};
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ev;
        if (rst_n) begin
            ev = pend && (cyc == pend_acc + pend_n);
            chk("rsp_valid", rsp_valid, ev);
            chk("req_ready", req_ready, !pend);
            chk("rd_wr_excl", mem_read & mem_write, 0);
            if (!mem_write) chk("din_zero", mem_din, 0);
            if (mem_read || mem_write) begin
                if (pend && pend_nth < pend_n) begin
                    chk("op_kind", mem_write, pend_write);
                    chk("op_cycle", cyc, pend_acc + pend_nth);
                    chk("op_addr", mem_addr, op_addr[pend_nth]);
                    if (mem_write) chk("op_din", mem_din, op_byte[pend_nth]);
                    if (mem_read) reads_now++;
                    pend_nth++;
                end else begin
                    chk("spurious_op", {mem_read, mem_write}, 0);
                end
            end else if (!pend) begin
                chk("addr_idle", mem_addr, 0);
            end
            if (ev) begin
                chk("rsp_err", rsp_err, pend_err);
                chk("op_count", pend_nth, pend_n);
                if (pend_upd) model_rdata = pend_rdata;
                rsp_cyc    = cyc + 1;
                last_reads = reads_now;
                last_err   = rsp_err;
                pend       = 1'b0;
            end
            chk("rsp_rdata", rsp_rdata, model_rdata);
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] v);
        mem[a]   = v;
        ref_m[a] = v;
    endtask

    // Issues one request and waits for its completion (bounded)
    task automatic do_req(input bit w, input bit b, input logic [15:0] a,
                          input logic [15:0] d);
        int start;
        int n;
        @(negedge clk);
        start     = acc_cnt;
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (acc_cnt == start && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accepted", acc_cnt - start, 1);
        req_valid = 1'b0;
        req_addr  = 16'h5A5A;
        req_wdata = 16'h0F0F;
        n = 0;
        while (pend && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rsp_timeout", pend, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int offs[$];
        int prev;
        int base;
        int bad;
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 8'h00;
            ref_m[i] = 8'h00;
        end
        preload(16'h0010, 8'h34);
        preload(16'h0011, 8'h12);
        preload(16'h0030, 8'h11);
        preload(16'h0031, 8'h77);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_mem", {mem_read, mem_write, mem_addr, mem_din}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Word load at 0x0010
        do_req(1'b0, 1'b0, 16'h0010, 16'h0000);
        chk("ld10_data", rsp_rdata, 16'h1234);
        chk("ld10_lat", rsp_cyc - pend_acc, 3);
        chk("ld10_reads", last_reads, 2);

        // Word store then load back
        do_req(1'b1, 1'b0, 16'h0020, 16'hBEEF);
        chk("st20_lo", mem[16'h0020], 8'hEF);
        chk("st20_hi", mem[16'h0021], 8'hBE);
        chk("st20_hold", rsp_rdata, 16'h1234);
        do_req(1'b0, 1'b0, 16'h0020, 16'h0000);
        chk("ld20_data", rsp_rdata, 16'hBEEF);

        // Byte load zero-extends
        do_req(1'b0, 1'b1, 16'h0011, 16'h0000);
        chk("ldb11_data", rsp_rdata, 16'h0012);
        chk("ldb11_lat", rsp_cyc - pend_acc, 2);
        chk("ldb11_reads", last_reads, 1);

        // Byte store at top of memory, then word load across the wrap
        do_req(1'b1, 1'b1, 16'hFFFF, 16'h00AA);
        chk("stbFFFF", mem[16'hFFFF], 8'hAA);
        preload(16'h0000, 8'h55);
        do_req(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        if (ALIGN) begin
            chk("wrap_err", last_err, 1);
            chk("wrap_hold", rsp_rdata, 16'h0012);
            chk("wrap_reads", last_reads, 0);
            chk("wrap_lat", rsp_cyc - pend_acc, 1);
        end else begin
            chk("wrap_err", last_err, 0);
            chk("wrap_data", rsp_rdata, 16'h55AA);
            chk("wrap_reads", last_reads, 2);
        end

        // Back-to-back word loads with req_valid held for 10 edges
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0010;
        base      = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            prev = acc_cnt;
            @(posedge clk);
            #1;
            if (acc_cnt != prev) offs.push_back(cyc - base);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 20 && pend; i++) begin
            @(posedge clk);
            #1;
        end
        chk("b2b_count", offs.size(), 3);
        if (offs.size() == 3) begin
            chk("b2b_off0", offs[0], 0);
            chk("b2b_off1", offs[1], 4);
            chk("b2b_off2", offs[2], 8);
        end
        chk("b2b_data", rsp_rdata, 16'h1234);

        // Reset during the high-byte cycle of a word store
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'h0030;
        req_wdata = 16'hCAFE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hi_write", mem_write, 1);
        chk("hi_addr", mem_addr, 16'h0031);
        rst_n = 1'b0;
        #1;
        chk("rstmid_write", mem_write, 0);
        chk("rstmid_ready", req_ready, 1);
        chk("rstmid_valid", rsp_valid, 0);
        chk("rstmid_rdata", rsp_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_lo", mem[16'h0030], 8'hFE);
        chk("rstmid_hi", mem[16'h0031], 8'h77);
        chk("post_ready", req_ready, 1);

        // Whole-memory image versus reference
        bad = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== ref_m[i]) bad++;
        chk("mem_image", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
